// File: rtl/odd_parity_tx.sv
// Odd-parity serial transmitter: start bit, DATA_W data bits LSB first,
// odd parity bit, stop bit; each bit held for CLKS_PER_BIT clocks.
module odd_parity_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    output logic              tx,
    output logic              busy,
    output logic              parity_out
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [7:0] LAST_CLK = 8'(CLKS_PER_BIT - 1);
    localparam logic [4:0] LAST_BIT = 5'(DATA_W - 1);

    // XNOR reduction: data plus this bit always holds an odd number of ones
    function automatic logic odd_parity(input logic [DATA_W-1:0] d);
        return ~^d;
    endfunction

    state_t            state_r, state_s;
    logic [7:0]        clk_cnt_r, clk_cnt_s;
    logic [4:0]        bit_idx_r, bit_idx_s;
    logic [DATA_W-1:0] shift_r, shift_s;
    logic              tx_r, tx_s;
    logic              busy_r, busy_s;
    logic              ready_r, ready_s;
    logic              parity_r, parity_s;
    logic              clk_end_s;

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            clk_cnt_r <= 8'd0;
            bit_idx_r <= 5'd0;
            shift_r   <= '0;
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
            ready_r   <= 1'b0;
            parity_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            clk_cnt_r <= clk_cnt_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
            tx_r      <= tx_s;
            busy_r    <= busy_s;
            ready_r   <= ready_s;
            parity_r  <= parity_s;
        end
    end

    // Next-state and next-output logic; tx is computed one edge ahead so it stays registered
    always_comb begin
        state_s   = state_r;
        clk_cnt_s = clk_cnt_r;
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        tx_s      = tx_r;
        busy_s    = busy_r;
        ready_s   = ready_r;
        parity_s  = parity_r;
        clk_end_s = (clk_cnt_r == LAST_CLK);

        case (state_r)
            IDLE: begin
                if (valid && ready_r) begin
                    state_s   = START;
                    shift_s   = data_in;
                    parity_s  = odd_parity(data_in);
                    tx_s      = 1'b0;
                    busy_s    = 1'b1;
                    ready_s   = 1'b0;
                    clk_cnt_s = 8'd0;
                    bit_idx_s = 5'd0;
                end else begin
                    tx_s      = 1'b1;
                    busy_s    = 1'b0;
                    ready_s   = 1'b1;
                end
            end
            START: begin
                if (clk_end_s) begin
                    state_s   = DATA;
                    tx_s      = shift_r[0];
                    shift_s   = shift_r >> 1'b1;
                    clk_cnt_s = 8'd0;
                    bit_idx_s = 5'd0;
                end else begin
                    clk_cnt_s = clk_cnt_r + 8'd1;
                end
            end
            DATA: begin
                if (clk_end_s) begin
                    clk_cnt_s = 8'd0;
                    if (bit_idx_r == LAST_BIT) begin
                        state_s = PARITY;
                        tx_s    = parity_r;
                    end else begin
                        bit_idx_s = bit_idx_r + 5'd1;
                        tx_s      = shift_r[0];
                        shift_s   = shift_r >> 1'b1;
                    end
                end else begin
                    clk_cnt_s = clk_cnt_r + 8'd1;
                end
            end
            PARITY: begin
                if (clk_end_s) begin
                    state_s   = STOP;
                    tx_s      = 1'b1;
                    clk_cnt_s = 8'd0;
                end else begin
                    clk_cnt_s = clk_cnt_r + 8'd1;
                end
            end
            STOP: begin
                if (clk_end_s) begin
                    state_s   = IDLE;
                    tx_s      = 1'b1;
                    busy_s    = 1'b0;
                    ready_s   = 1'b1;
                    clk_cnt_s = 8'd0;
                    bit_idx_s = 5'd0;
                end else begin
                    clk_cnt_s = clk_cnt_r + 8'd1;
                end
            end
            default: begin
                state_s   = IDLE;
                tx_s      = 1'b1;
                busy_s    = 1'b0;
                ready_s   = 1'b0;
                clk_cnt_s = 8'd0;
                bit_idx_s = 5'd0;
            end
        endcase
    end

    assign tx         = tx_r;
    assign busy       = busy_r;
    assign ready      = ready_r;
    assign parity_out = parity_r;

endmodule

// File: doc/odd_parity_tx.md
ODD_PARITY_TX -- requirements
Module: odd_parity_tx

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the payload width in bits (legal range 1..16).
REQ-002 Parameter CLKS_PER_BIT, default 4, SHALL set the number of clk cycles each serial bit is held (legal range 1..255).
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 data_in  input  DATA_W  SHALL carry the parallel payload, sampled only on an accept edge.
REQ-006 valid  input  1  SHALL indicate that data_in holds a word to send.
REQ-007 ready  output  1  SHALL indicate the block can accept a word this cycle.
REQ-008 tx  output  1  SHALL be the serial line (idle/mark = 1).
REQ-009 busy  output  1  SHALL be high while a frame is in progress.
REQ-010 parity_out  output  1  SHALL expose the odd-parity bit of the most recently accepted word.

Function
REQ-011 The block SHALL serialise each accepted word as one frame: start bit (0), DATA_W data bits LSB first, one parity bit, one stop bit (1).
REQ-012 The parity bit SHALL be odd parity, i.e. the XNOR-reduction of the latched word, so that data bits plus parity contain an odd number of 1s.
REQ-013 The FSM SHALL have exactly the states IDLE, START, DATA, PARITY and STOP.
REQ-014 An accept SHALL occur on a rising edge where valid=1 and ready=1; ready SHALL be 1 only in IDLE.
REQ-015 On accept, the block SHALL latch data_in, latch the computed parity into parity_out, set tx=0, set busy=1, ready=0, and enter START, all on the same edge.
REQ-016 Each of START, every DATA bit, PARITY and STOP SHALL drive tx for exactly CLKS_PER_BIT cycles; tx SHALL be registered (glitch-free).
REQ-017 A bit counter SHALL index DATA bits 0..DATA_W-1; PARITY SHALL be entered after bit DATA_W-1 completes, and STOP after PARITY completes.
REQ-018 After the last STOP cycle, the FSM SHALL return to IDLE with tx=1, busy=0, ready=1; total frame length SHALL be (DATA_W+3)*CLKS_PER_BIT cycles.
REQ-019 valid asserted while busy=1 SHALL be ignored, and data_in changes while busy=1 SHALL NOT affect the frame in flight.
REQ-020 Back-to-back: with valid held high, the next accept SHALL occur on the first edge where ready=1, giving exactly one idle (tx=1) cycle between frames.
REQ-021 parity_out SHALL hold its value until the next accept.
REQ-022 With CLKS_PER_BIT=1, every bit SHALL last exactly one cycle with no skipped or repeated bits.

Reset
REQ-023 While rst_n=0, outputs SHALL be tx=1, busy=0, ready=0, parity_out=0; state SHALL be IDLE, and counters and the data latch SHALL be 0.
REQ-024 Assertion of rst_n mid-frame SHALL abort the frame immediately (asynchronously) with no further data bits sent.
REQ-025 ready SHALL rise on the first rising clk edge after rst_n deasserts.

Verification
REQ-026 Defaults, send 8'h00 -> tx sequence 0,0,0,0,0,0,0,0,0,1(parity),1(stop), each bit 4 cycles, parity_out=1, frame 44 cycles.
REQ-027 Send 8'h01 then 8'hFF back-to-back with valid held high -> parity 0 then 1, data LSB first, exactly one idle cycle between frames.
REQ-028 Send 8'hA5 -> data bits 1,0,1,0,0,1,0,1, parity 1; pulse valid with 8'h3C during the frame -> ignored, tx unchanged.
REQ-029 Assert rst_n=0 during data bit 3 -> tx=1, busy=0 immediately, before the next clk edge; after release, ready=1 on the first edge and a new 8'h55 frame (parity 1) is sent correctly.
REQ-030 DATA_W=3, CLKS_PER_BIT=1, sweep all 8 inputs 3'b000..3'b111 -> parity 1,0,0,1,0,1,1,0 and 6-cycle frames.
